// File: rtl/gpr_wb_ctrl_pkg.sv
// Shared CPU header for the GPR writeback path: register-file geometry,
// starvation FSM encoding, active-low write-enable levels and the queued result format.
package gpr_wb_ctrl_pkg;

    localparam int REG_NUM = 32;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    localparam logic WE_ON  = 1'b0;
    localparam logic WE_OFF = 1'b1;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ml_entry_t;

    function automatic logic is_r0(input logic [ADDR_W-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/gpr_wb_ctrl_if.sv
// Upstream-facing bundle of the writeback controller: execute results,
// multi-cycle results with their ready handshake, and multi-cycle issue notices.
interface gpr_wb_ctrl_if;
    import gpr_wb_ctrl_pkg::*;

    logic              ex_valid;
    logic [ADDR_W-1:0] ex_addr;
    logic [DATA_W-1:0] ex_data;

    logic              ml_valid;
    logic              ml_ready;
    logic [ADDR_W-1:0] ml_addr;
    logic [DATA_W-1:0] ml_data;

    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;

    modport master (
        output ex_valid, ex_addr, ex_data,
        output ml_valid, ml_addr, ml_data,
        output iss_valid, iss_addr,
        input  ml_ready
    );

    modport slave (
        input  ex_valid, ex_addr, ex_data,
        input  ml_valid, ml_addr, ml_data,
        input  iss_valid, iss_addr,
        output ml_ready
    );

endinterface

// File: rtl/gpr_wb_fifo.sv
// Small synchronous FIFO for multi-cycle results; DEPTH must be a power of two
// so the pointers wrap naturally. A push while full is refused even if a pop coincides.
module gpr_wb_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/gpr_wb_ctrl.sv
// GPR writeback controller: merges execute and queued multi-cycle results into one
// registered write per cycle. Optional macro GPR_WB_R0_ZERO_EN suppresses writes to r0.
module gpr_wb_ctrl
    import gpr_wb_ctrl_pkg::*;
#(
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    gpr_wb_ctrl_if.slave      bus,
    input  logic [ADDR_W-1:0] chk_addr_0,
    input  logic [ADDR_W-1:0] chk_addr_1,
    output logic              chk_busy_0,
    output logic              chk_busy_1,
    output logic              ex_stall,
    output logic              waw_err,
    output logic              we_,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
    localparam int DEF_W = $clog2(STARVE_MAX + 1);

    wb_state_t          state;
    wb_state_t          state_next;
    logic [DEF_W-1:0]   defer_cnt;
    logic [DEF_W-1:0]   defer_next;
    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_next;

    ml_entry_t          fifo_din;
    ml_entry_t          fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               sel_ex;

    logic               we_next;
    logic               waw_next;
    logic [ADDR_W-1:0]  wr_addr_next;
    logic [DATA_W-1:0]  wr_data_next;

    assign bus.ml_ready = !reset && (fifo_count < CNT_W'(LQ_DEPTH));
    assign push         = bus.ml_valid && bus.ml_ready;
    assign fifo_din     = '{addr: bus.ml_addr, data: bus.ml_data};

    assign ex_stall   = (state == HOLD);
    assign chk_busy_0 = busy[chk_addr_0];
    assign chk_busy_1 = busy[chk_addr_1];

    gpr_wb_fifo #(
        .DEPTH (LQ_DEPTH),
        .WIDTH ($bits(ml_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Arbitration, starvation tracking and scoreboard update for the coming edge.
    always_comb begin
        sel_ex     = bus.ex_valid && !ex_stall;
        pop        = !sel_ex && !fifo_empty;
        state_next = state;
        defer_next = defer_cnt;
        busy_next  = busy;

        case (state)
            RUN: begin
                if (pop) begin
                    defer_next = '0;
                end else if (!fifo_empty) begin
                    defer_next = defer_cnt + DEF_W'(1);
                end
                if (!fifo_empty && (defer_cnt == DEF_W'(STARVE_MAX - 1))) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                state_next = RUN;
                defer_next = '0;
            end
            default: begin
                state_next = RUN;
                defer_next = '0;
            end
        endcase

        // An issue to the same register as a retiring entry keeps it busy.
        if (pop) begin
            busy_next[fifo_head.addr] = 1'b0;
        end
        if (bus.iss_valid) begin
            busy_next[bus.iss_addr] = 1'b1;
        end
    end

    // Next values of the registered write port and the WAW flag.
    always_comb begin
        we_next      = WE_OFF;
        waw_next     = 1'b0;
        wr_addr_next = wr_addr;
        wr_data_next = wr_data;

        if (sel_ex) begin
            we_next      = WE_ON;
            wr_addr_next = bus.ex_addr;
            wr_data_next = bus.ex_data;
            waw_next     = busy[bus.ex_addr];
        end else if (pop) begin
            we_next      = WE_ON;
            wr_addr_next = fifo_head.addr;
            wr_data_next = fifo_head.data;
        end

`ifdef GPR_WB_R0_ZERO_EN
        if (is_r0(wr_addr_next)) begin
            we_next  = WE_OFF;
            waw_next = 1'b0;
        end
`else
        we_next = we_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            defer_cnt <= '0;
            busy      <= '0;
            we_       <= WE_OFF;
            wr_addr   <= '0;
            wr_data   <= '0;
            waw_err   <= 1'b0;
        end else begin
            state     <= state_next;
            defer_cnt <= defer_next;
            busy      <= busy_next;
            we_       <= we_next;
            wr_addr   <= wr_addr_next;
            wr_data   <= wr_data_next;
            waw_err   <= waw_next;
        end
    end

    // The ready handshake must never let a push reach a full queue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && fifo_full));
        end
    end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed self-checking bench for gpr_wb_ctrl (LQ_DEPTH=2, STARVE_MAX=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_gpr_wb_ctrl;
    import gpr_wb_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] chk_addr_0;
    logic [ADDR_W-1:0] chk_addr_1;
    logic              chk_busy_0;
    logic              chk_busy_1;
    logic              ex_stall;
    logic              waw_err;
    logic              we_;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    int total = 0;
    int bad   = 0;

    gpr_wb_ctrl_if bus();

    gpr_wb_ctrl #(
        .LQ_DEPTH   (2),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .chk_addr_0 (chk_addr_0),
        .chk_addr_1 (chk_addr_1),
        .chk_busy_0 (chk_busy_0),
        .chk_busy_1 (chk_busy_1),
        .ex_stall   (ex_stall),
        .waw_err    (waw_err),
        .we_        (we_),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(
        input logic              exv,
        input logic [ADDR_W-1:0] exa,
        input logic [DATA_W-1:0] exd,
        input logic              mlv,
        input logic [ADDR_W-1:0] mla,
        input logic [DATA_W-1:0] mld,
        input logic              issv,
        input logic [ADDR_W-1:0] issa
    );
        bus.ex_valid  = exv;
        bus.ex_addr   = exa;
        bus.ex_data   = exd;
        bus.ml_valid  = mlv;
        bus.ml_addr   = mla;
        bus.ml_data   = mld;
        bus.iss_valid = issv;
        bus.iss_addr  = issa;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        chk_addr_0 = 5'd7;
        chk_addr_1 = 5'd6;
        idle();
        repeat (3) tick();

        checkOutput("rst_we",      32'(we_),          1);
        checkOutput("rst_waddr",   32'(wr_addr),      0);
        checkOutput("rst_wdata",   wr_data,           0);
        checkOutput("rst_ready",   32'(bus.ml_ready), 0);
        checkOutput("rst_stall",   32'(ex_stall),     0);
        checkOutput("rst_waw",     32'(waw_err),      0);
        checkOutput("rst_busy7",   32'(chk_busy_0),   0);
        checkOutput("rst_busy6",   32'(chk_busy_1),   0);

        reset = 1'b0;
        tick();
        checkOutput("ready_post_rst", 32'(bus.ml_ready), 1);
        checkOutput("idle_we",        32'(we_),          1);

        // Plain execute write
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        idle();
        checkOutput("ex_we",    32'(we_),     0);
        checkOutput("ex_waddr", 32'(wr_addr), 5);
        checkOutput("ex_wdata", wr_data,      32'hDEADBEEF);
        checkOutput("ex_waw",   32'(waw_err), 0);
        tick();
        checkOutput("hold_we",    32'(we_),     1);
        checkOutput("hold_waddr", 32'(wr_addr), 5);
        checkOutput("hold_wdata", wr_data,      32'hDEADBEEF);

        // Scoreboard set, then retire through the queue
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        tick();
        idle();
        checkOutput("sb_busy7", 32'(chk_busy_0), 1);
        checkOutput("sb_busy6", 32'(chk_busy_1), 0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
        tick();
        idle();
        checkOutput("ml_queued_we", 32'(we_),        1);
        checkOutput("ml_busy_held", 32'(chk_busy_0), 1);
        tick();
        checkOutput("ml_we",      32'(we_),        0);
        checkOutput("ml_waddr",   32'(wr_addr),    7);
        checkOutput("ml_wdata",   wr_data,         32'h1234);
        checkOutput("ml_cleared", 32'(chk_busy_0), 0);

        // Fill the queue while execute owns the port
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'hA9, 1'b0, 5'd0);
        tick();
        checkOutput("fill1_waddr", 32'(wr_addr),      1);
        checkOutput("fill1_ready", 32'(bus.ml_ready), 1);
        applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0);
        tick();
        checkOutput("fill2_waddr", 32'(wr_addr),      2);
        checkOutput("fill2_wdata", wr_data,           32'h22);
        checkOutput("full_ready",  32'(bus.ml_ready), 0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hAB, 1'b0, 5'd0);
        tick();
        checkOutput("drain1_we",    32'(we_),          0);
        checkOutput("drain1_waddr", 32'(wr_addr),      9);
        checkOutput("drain1_wdata", wr_data,           32'hA9);
        checkOutput("drain1_ready", 32'(bus.ml_ready), 1);
        tick();
        idle();
        checkOutput("drain2_waddr", 32'(wr_addr), 10);
        checkOutput("drain2_wdata", wr_data,      32'hAA);
        tick();
        checkOutput("drain3_waddr", 32'(wr_addr), 11);
        checkOutput("drain3_wdata", wr_data,      32'hAB);
        tick();
        checkOutput("drained_we", 32'(we_), 1);

        // Starvation: one queued entry against continuous execute traffic
        applyStimulus(1'b1, 5'd20, 32'h100, 1'b1, 5'd12, 32'hC0DE, 1'b0, 5'd0);
        tick();
        checkOutput("starve_push_waddr", 32'(wr_addr),  20);
        checkOutput("starve_push_stall", 32'(ex_stall), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'(21 + i), 32'h101 + i, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            tick();
            checkOutput("starve_defer_waddr", 32'(wr_addr),  21 + i);
            checkOutput("starve_defer_stall", 32'(ex_stall), (i == 3) ? 1 : 0);
        end
        applyStimulus(1'b1, 5'd25, 32'h105, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        checkOutput("hold_pop_we",    32'(we_),      0);
        checkOutput("hold_pop_waddr", 32'(wr_addr),  12);
        checkOutput("hold_pop_wdata", wr_data,       32'hC0DE);
        checkOutput("hold_release",   32'(ex_stall), 0);
        applyStimulus(1'b1, 5'd26, 32'h106, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        idle();
        checkOutput("replay_waddr", 32'(wr_addr), 26);
        checkOutput("replay_wdata", wr_data,      32'h106);

        // WAW on an outstanding multi-cycle destination
        chk_addr_0 = 5'd3;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        tick();
        idle();
        checkOutput("waw_busy3", 32'(chk_busy_0), 1);
        applyStimulus(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        idle();
        checkOutput("waw_pulse", 32'(waw_err), 1);
        checkOutput("waw_we",    32'(we_),     0);
        checkOutput("waw_waddr", 32'(wr_addr), 3);
        checkOutput("waw_wdata", wr_data,      32'h3333);
        tick();
        checkOutput("waw_drop",  32'(waw_err),    0);
        checkOutput("waw_still", 32'(chk_busy_0), 1);

        // Execute write to r0
        applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        idle();
`ifdef GPR_WB_R0_ZERO_EN
        checkOutput("r0_we", 32'(we_), 1);
`else
        checkOutput("r0_we", 32'(we_), 0);
`endif
        checkOutput("r0_waddr", 32'(wr_addr), 0);
        checkOutput("r0_waw",   32'(waw_err), 0);

        // Issue and retire of the same register in one cycle keeps it busy
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h5, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        tick();
        idle();
        checkOutput("setwin_waddr", 32'(wr_addr),    3);
        checkOutput("setwin_wdata", wr_data,         32'h5);
        checkOutput("setwin_busy",  32'(chk_busy_0), 1);

        // Reset with a queued entry and a busy register
        chk_addr_1 = 5'd8;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd8);
        tick();
        idle();
        checkOutput("mid_busy8", 32'(chk_busy_1), 1);
        reset = 1'b1;
        tick();
        checkOutput("mid_rst_ready", 32'(bus.ml_ready), 0);
        checkOutput("mid_rst_we",    32'(we_),          1);
        checkOutput("mid_rst_waddr", 32'(wr_addr),      0);
        checkOutput("mid_rst_busy8", 32'(chk_busy_1),   0);
        checkOutput("mid_rst_busy3", 32'(chk_busy_0),   0);
        reset = 1'b0;
        tick();
        checkOutput("mid_post_we", 32'(we_), 1);
        tick();
        checkOutput("mid_post_we2",    32'(we_),     1);
        checkOutput("mid_post_wdata",  wr_data,      0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_wb_ctrl.md
# gpr_wb_ctrl

Writeback controller that drives the general-purpose register file write port. It merges results from the single-cycle execute path and a multi-cycle path (loads, multiply/divide) into one registered write per cycle. It buffers multi-cycle results in a small FIFO and keeps a per-register busy scoreboard for hazard checks. It sits between the EX/MEM stages and the register file, on the writer side of its write port.

## Interface
- REG_NUM, 32, number of GPRs
- ADDR_W, 5, register address width
- DATA_W, 32, data width
- LQ_DEPTH, 2, multi-cycle result FIFO depth (power of two, ≥2)
- STARVE_MAX, 4, cycles a FIFO head may be deferred before a stall request
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  execute result valid; no backpressure
- ex_addr  in  ADDR_W  execute destination
- ex_data  in  DATA_W  execute result
- ml_valid  in  1  multi-cycle result valid
- ml_ready  out  1  FIFO can accept
- ml_addr  in  ADDR_W  multi-cycle destination
- ml_data  in  DATA_W  multi-cycle result
- iss_valid  in  1  multi-cycle op issued; marks iss_addr busy
- iss_addr  in  ADDR_W  issued op destination
- chk_addr_0, chk_addr_1  in  ADDR_W  scoreboard lookup addresses
- chk_busy_0, chk_busy_1  out  1  combinational busy[chk_addr_n]
- ex_stall  out  1  request to hold the execute path for one cycle
- waw_err  out  1  execute write to a busy register
- we_  out  1  GPR write enable, active-low
- wr_addr  out  ADDR_W  GPR write address
- wr_data  out  DATA_W  GPR write data

## Operation
- FIFO push: ml_valid && ml_ready. ml_ready = !reset && (count < LQ_DEPTH), computed from the registered count. A push while full is never accepted, even if a pop occurs in the same cycle.
- No bypass: every multi-cycle result passes through the FIFO.
- Select, in priority order:
  - ex_valid && !ex_stall selects EX.
  - Otherwise, a non-empty FIFO pops its head.
  - Otherwise, idle.
- Selection is registered onto we_/wr_addr/wr_data. Idle drives we_=1; wr_addr and wr_data hold their previous values.
- Starvation FSM, states RUN and HOLD:
  - RUN: defer_cnt increments each cycle the FIFO is non-empty and EX wins. It clears on any pop.
  - RUN → HOLD: when defer_cnt == STARVE_MAX-1 and the FIFO is non-empty.
  - HOLD: ex_stall=1 for exactly one cycle. The FIFO head is written; any ex_valid in this cycle is ignored and upstream must replay it. HOLD → RUN unconditionally, and defer_cnt is cleared.
- Scoreboard, busy[REG_NUM]:
  - Set on iss_valid.
  - Cleared when a FIFO entry for that address is selected for write.
  - Set and clear of the same address in the same cycle: set wins.
- waw_err: one-cycle registered pulse when EX is selected and busy[ex_addr]=1. The write still proceeds.

## Timing
- Reset values: we_=1, wr_addr=0, wr_data=0, ml_ready=0 during reset, ex_stall=0, waw_err=0, busy=0, FIFO empty, FSM=RUN, defer_cnt=0.
- Reset mid-operation discards FIFO contents and the scoreboard.
- EX latency: result on wr_* at edge N+1 for ex_valid at edge N.
- ML latency: minimum 2 edges from acceptance, 1 edge into the FIFO and 1 edge to wr_*.
- chk_busy reflects the registered busy state, so a clear becomes visible the cycle after the pop edge.
- ml_ready first rises the cycle after reset deasserts.
- FIFO pointers wrap modulo LQ_DEPTH; count is $clog2(LQ_DEPTH)+1 bits.

## Configuration
- GPR_WB_R0_ZERO_EN
  - Defined: selections with destination address 0 still consume their slot and still clear busy, but drive we_=1, so r0 is never written. waw_err is suppressed for address 0.
  - Undefined: r0 is written like any other register.

## Structure
- The shared CPU header package holds REG_NUM, ADDR_W, DATA_W, the FSM state encodings (RUN/HOLD), and the active-low enable constants.
- One natural sub-module, gpr_wb_fifo: a parameterised synchronous FIFO with push, pop, head, count, full, and empty. The controller instantiates it once.

## Test plan
- Reset: reset high 3 cycles → we_=1, ml_ready=0, busy all 0. ml_ready=1 one cycle after release.
- EX write: ex_valid, addr 5, 0xDEADBEEF → next cycle we_=0, wr_addr=5, wr_data=0xDEADBEEF. waw_err=0.
- Scoreboard:
  - iss_valid addr 7 → chk_busy(7)=1 next cycle.
  - ml push addr 7, 0x1234 with no EX → wr_* 2 cycles later. chk_busy(7)=0 the cycle after the write.
- Full FIFO: two pushes while ex_valid is held high → ml_ready=0 and a third ml_valid is held off. The FIFO drains in order once ex_valid drops.
- Starvation: FIFO non-empty and ex_valid continuous → ex_stall pulses on the 4th deferral cycle. The FIFO head is written that cycle; the EX write is dropped.
- With GPR_WB_R0_ZERO_EN defined: ex write to addr 0 → we_ stays 1.
- WAW: iss addr 3, then ex write addr 3 → waw_err pulses once and the write occurs.
